// File: rtl/ion_frame_serializer.sv
// Ion packet framer: buffers up to two sensor packets and streams each one as
// a start byte, MSB-first payload bytes and an XOR checksum over a valid/ack byte link.
module ion_frame_serializer #(
   parameter int unsigned PACKET_WIDTH  = 110,
   parameter int unsigned PAYLOAD_BYTES = 14,
   parameter logic [7:0]  START_BYTE    = 8'h7E
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    packet_valid,
   input  logic [PACKET_WIDTH-1:0] packet_in,
   output logic [7:0]              byte_out,
   output logic                    byte_valid,
   input  logic                    byte_ack,
   output logic                    busy,
   output logic                    overflow,
   output logic [15:0]             frames_sent
);

   localparam int unsigned SHIFT_WIDTH = PAYLOAD_BYTES * 8;
   localparam int unsigned IDX_W       = $clog2(PAYLOAD_BYTES + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND_START,
      SEND_DATA,
      SEND_CSUM,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [PACKET_WIDTH-1:0] fifo_mem [2];
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              fifo_count;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    push;
   logic                    pop;
   logic                    drop;

   logic [SHIFT_WIDTH-1:0]  shift_reg;
   logic [7:0]              checksum;
   logic [IDX_W-1:0]        byte_idx;
   logic                    last_payload;

   // FIFO control: a pop in LOAD frees a slot for a strobe in the same cycle.
   always_comb begin
      fifo_empty = (fifo_count == 2'd0);
      fifo_full  = (fifo_count == 2'd2);
      pop        = (state == LOAD);
      push       = packet_valid && (!fifo_full || pop);
      drop       = packet_valid && fifo_full && !pop;
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= packet_in;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   assign last_payload = (byte_idx == IDX_W'(PAYLOAD_BYTES - 1));

   always_comb begin
      state_next = state;
      byte_out   = '0;
      byte_valid = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            state_next = SEND_START;
         end
         SEND_START: begin
            byte_out   = START_BYTE;
            byte_valid = 1'b1;
            if (byte_ack) begin
               state_next = SEND_DATA;
            end
         end
         SEND_DATA: begin
            byte_out   = shift_reg[SHIFT_WIDTH-1 -: 8];
            byte_valid = 1'b1;
            if (byte_ack && last_payload) begin
               state_next = SEND_CSUM;
            end
         end
         SEND_CSUM: begin
            byte_out   = checksum;
            byte_valid = 1'b1;
            if (byte_ack) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Payload is zero-extended at the MSB so the top byte leaves first.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         shift_reg   <= '0;
         checksum    <= '0;
         byte_idx    <= '0;
         frames_sent <= '0;
      end else begin
         case (state)
            LOAD: begin
               shift_reg <= SHIFT_WIDTH'(fifo_mem[rd_ptr]);
               checksum  <= '0;
               byte_idx  <= '0;
            end
            SEND_DATA: begin
               if (byte_ack) begin
                  shift_reg <= shift_reg << 8;
                  checksum  <= checksum ^ shift_reg[SHIFT_WIDTH-1 -: 8];
                  byte_idx  <= byte_idx + IDX_W'(1);
               end
            end
            DONE: begin
               frames_sent <= frames_sent + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ion_frame_serializer.sv
// Scoreboard bench for ion_frame_serializer: expected frame bytes are queued at
// each accepted strobe and retired by a monitor at every byte handshake.
module tb_ion_frame_serializer;

   logic         clock;
   logic         resetn;
   logic         packet_valid;
   logic [109:0] packet_in;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic         byte_ack;
   logic         busy;
   logic         overflow;
   logic [15:0]  frames_sent;

   int           vectors;
   int           miscompares;
   logic [7:0]   sb[$];
   logic [15:0]  exp_frames;
   int           ack_mode;
   int           stall_left;
   logic         stalled_prev;
   logic [7:0]   prev_byte;

   ion_frame_serializer #(
      .PACKET_WIDTH (110),
      .PAYLOAD_BYTES(14),
      .START_BYTE   (8'h7E)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .packet_valid(packet_valid),
      .packet_in   (packet_in),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .byte_ack    (byte_ack),
      .busy        (busy),
      .overflow    (overflow),
      .frames_sent (frames_sent)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void push_frame(input logic [109:0] p);
      logic [111:0] s;
      logic [7:0]   c;
      logic [7:0]   b;
      s = {2'b00, p};
      c = 8'h00;
      sb.push_back(8'h7E);
      for (int i = 0; i < 14; i++) begin
         b = s[111 - 8*i -: 8];
         sb.push_back(b);
         c = c ^ b;
      end
      sb.push_back(c);
      exp_frames = exp_frames + 16'd1;
   endfunction

   function automatic logic [109:0] rand_packet();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[109:0];
   endfunction

   // Monitor: acts 1 time unit after each falling edge, choosing byte_ack for
   // the coming rising edge and checking the byte that edge will transfer.
   always begin
      @(negedge clock);
      #1;
      if (!resetn) begin
         stalled_prev = 1'b0;
         byte_ack     = 1'b0;
      end else begin
         case (ack_mode)
            0: byte_ack = 1'b1;
            2: byte_ack = 1'b0;
            default: begin
               if (byte_valid) begin
                  if (stall_left == 0) begin
                     byte_ack = 1'b1;
                  end else begin
                     byte_ack   = 1'b0;
                     stall_left = stall_left - 1;
                  end
               end else begin
                  byte_ack = 1'($urandom_range(0, 1));
               end
            end
         endcase
         if (stalled_prev) begin
            vectors++;
            if (byte_valid !== 1'b1 || byte_out !== prev_byte) begin
               miscompares++;
               $display("FAIL stall_hold: valid=%b byte=%h, required valid=1 byte=%h",
                        byte_valid, byte_out, prev_byte);
            end
         end
         if (byte_valid && byte_ack) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL extra_byte: got %h, required no byte", byte_out);
            end else begin
               logic [7:0] e;
               e = sb.pop_front();
               if (byte_out !== e) begin
                  miscompares++;
                  $display("FAIL byte_stream: got %h, required %h", byte_out, e);
               end
            end
            if (ack_mode == 1) stall_left = $urandom_range(0, 5);
         end
         stalled_prev = byte_valid && !byte_ack;
         prev_byte    = byte_out;
      end
   end

   task automatic strobe(input logic [109:0] p, input bit accepted);
      @(negedge clock);
      packet_valid = 1'b1;
      packet_in    = p;
      if (accepted) push_frame(p);
      @(negedge clock);
      packet_valid = 1'b0;
      packet_in    = '0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      vectors++;
      if (n >= 3000) begin
         miscompares++;
         $display("FAIL %s_timeout: %0d bytes outstanding, busy=%b, required 0 and 0",
                  name, sb.size(), busy);
      end
      @(negedge clock);
      vectors++;
      if (frames_sent !== exp_frames || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_frames: frames_sent=%0d busy=%b, required %0d busy=0",
                  name, frames_sent, busy, exp_frames);
      end
   endtask

   task automatic test_reset();
      resetn       = 1'b0;
      packet_valid = 1'b0;
      packet_in    = '0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      vectors++;
      if (byte_valid !== 1'b0 || byte_out !== 8'h00 || overflow !== 1'b0 ||
          frames_sent !== 16'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: valid=%b byte=%h ovf=%b frames=%0d busy=%b, required all 0",
                  byte_valid, byte_out, overflow, frames_sent, busy);
      end
   endtask

   task automatic test_single_frame();
      ack_mode = 0;
      // zero data without a strobe must not create a frame
      packet_in = '0;
      repeat (3) @(negedge clock);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_idle_data: busy=%b, required 0", busy);
      end
      strobe(110'hAB, 1'b1);
      vectors++;
      if (byte_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL latency_k: valid=%b busy=%b, required valid=0 busy=1", byte_valid, busy);
      end
      @(negedge clock);
      vectors++;
      if (byte_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL latency_k1: valid=%b, required 0", byte_valid);
      end
      @(negedge clock);
      vectors++;
      if (byte_valid !== 1'b1 || byte_out !== 8'h7E) begin
         miscompares++;
         $display("FAIL latency_k2: valid=%b byte=%h, required valid=1 byte=7e", byte_valid, byte_out);
      end
      drain("single");
   endtask

   task automatic test_all_ones();
      ack_mode = 0;
      strobe({110{1'b1}}, 1'b1);
      drain("all_ones");
   endtask

   task automatic test_stalls();
      ack_mode   = 1;
      stall_left = 3;
      strobe(110'hAB, 1'b1);
      drain("stall_ab");
      strobe(rand_packet(), 1'b1);
      drain("stall_rand");
      ack_mode = 0;
   endtask

   task automatic test_same_cycle_push_pop();
      logic [109:0] a;
      logic [109:0] b;
      logic [109:0] c;
      ack_mode = 0;
      a = rand_packet();
      b = rand_packet();
      c = rand_packet();
      // the third strobe lands while LOAD pops the full FIFO
      @(negedge clock);
      packet_valid = 1'b1; packet_in = a; push_frame(a);
      @(negedge clock);
      packet_in = b; push_frame(b);
      @(negedge clock);
      packet_in = c; push_frame(c);
      @(negedge clock);
      packet_valid = 1'b0; packet_in = '0;
      drain("push_pop");
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL push_pop_overflow: overflow=%b, required 0", overflow);
      end
   endtask

   task automatic test_overflow();
      logic [109:0] a;
      logic [109:0] b;
      logic [109:0] c;
      logic [109:0] d;
      ack_mode = 2;
      a = rand_packet();
      b = rand_packet();
      c = rand_packet();
      d = rand_packet();
      strobe(a, 1'b1);
      repeat (2) @(negedge clock);
      vectors++;
      if (byte_valid !== 1'b1 || byte_out !== 8'h7E) begin
         miscompares++;
         $display("FAIL ovf_stalled_start: valid=%b byte=%h, required 1 7e", byte_valid, byte_out);
      end
      @(negedge clock);
      packet_valid = 1'b1; packet_in = b; push_frame(b);
      @(negedge clock);
      packet_in = c; push_frame(c);
      @(negedge clock);
      packet_in = d;
      @(negedge clock);
      packet_valid = 1'b0; packet_in = '0;
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_set: overflow=%b, required 1", overflow);
      end
      ack_mode = 0;
      drain("overflow");
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: overflow=%b, required 1", overflow);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [109:0] p;
      logic [111:0] s;
      ack_mode = 0;
      p = rand_packet();
      s = {2'b00, p};
      strobe(p, 1'b1);
      repeat (8) @(negedge clock);
      vectors++;
      if (sb.size() != 10 || byte_valid !== 1'b1 || byte_out !== s[71:64]) begin
         miscompares++;
         $display("FAIL mid_frame_idx5: left=%0d valid=%b byte=%h, required 10 1 %h",
                  sb.size(), byte_valid, byte_out, s[71:64]);
      end
      resetn = 1'b0;
      sb.delete();
      exp_frames = 16'd0;
      @(negedge clock);
      resetn = 1'b1;
      vectors++;
      if (byte_valid !== 1'b0 || frames_sent !== 16'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: valid=%b frames=%0d ovf=%b busy=%b, required all 0",
                  byte_valid, frames_sent, overflow, busy);
      end
      repeat (4) @(negedge clock);
      vectors++;
      if (byte_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL aborted_frame: valid=%b busy=%b, required 0 0", byte_valid, busy);
      end
      strobe(110'h3_1234_5678_9ABC_DEF0_1357_9BDF, 1'b1);
      drain("after_reset");
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      exp_frames   = 16'd0;
      ack_mode     = 0;
      stall_left   = 0;
      stalled_prev = 1'b0;
      prev_byte    = 8'h00;
      byte_ack     = 1'b0;
      test_reset();
      test_single_frame();
      test_all_ones();
      test_stalls();
      test_same_cycle_push_pop();
      test_overflow();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

endmodule
